mybullet_app: RTL and testbench
===============================

Name: mybullet_app

Overview:
Bullet launcher and tracker for the player's tank. It consumes the tank's shoot level, position and direction, and manages up to four bullets in flight. Each bullet advances one grid cell per movement tick and is removed when it leaves the grid or when collision logic clears it. It drives the bulN_x/bulN_y positions that the tank and enemy hit checks compare against.

Parameters:
GRID_X, 16, number of columns; valid x is 0..GRID_X-1
GRID_Y, 20, number of rows; valid y is 0..GRID_Y-1
COOLDOWN, 2, move_tick count after an accepted shot before the next shot may be accepted; 0 disables the cooldown
OFF_POS, 5'd31, position driven on both axes of an inactive slot; must be outside the grid

Ports:
clk  in  1  system clock; the only clock
rst  in  1  reset, asynchronous, active-high
move_tick  in  1  one-clk strobe (nominal 4 Hz) synchronous to clk; advances bullets
bul_en  in  1  enable; 0 clears all slots and blocks new shots
bul_sht  in  1  shoot request level from the tank
tank_x  in  5  tank column
tank_y  in  5  tank row
tank_dir  in  2  direction: 00 = y+1, 01 = y-1, 10 = x+1, 11 = x-1
bul_clr  in  4  per-slot clear from collision logic (bit0 = slot1)
bul1_x, bul1_y, bul2_x, bul2_y, bul3_x, bul3_y, bul4_x, bul4_y  out  5 each  bullet positions, registered
bul_act  out  4  slot active flags, registered
shot_ok  out  1  one-clk pulse when a shot is accepted

Behaviour:
- Reset (async): all bul_act = 0, all positions = OFF_POS, shot_ok = 0, cooldown counter = 0, shoot edge register = 0.
- Edge detect: bul_sht is registered. A shot request is bul_sht=1 in the current cycle with the registered value 0. Holding the input high fires once only.
- Acceptance requires all of the following:
  - a shot request is present;
  - bul_en = 1;
  - cooldown counter = 0;
  - at least one slot is free;
  - the spawn cell (tank position stepped once in tank_dir) is inside the grid.
- If any condition fails, the request is dropped with no retry and no state change.
- On acceptance:
  - the lowest-index free slot loads the spawn cell, its tank_dir is latched, and its bul_act bit is set;
  - shot_ok pulses in the same cycle the new position registers update (1 clk after the edge is sampled);
  - the cooldown counter loads COOLDOWN.
- Step arithmetic is 5-bit. A step is out of grid if:
  - decrementing from 0 (underflow); or
  - the result is x >= GRID_X or y >= GRID_Y.
- On move_tick, each active slot steps once in its latched direction. If the result is out of grid, the slot clears (bul_act = 0, position = OFF_POS).
- On move_tick, the cooldown counter decrements by 1 if it is nonzero (saturates at 0).
- Per-slot priority, highest first:
  1. bul_en = 0 (clears all slots);
  2. bul_clr bit (clears that slot);
  3. move_tick step;
  4. spawn.
- A slot freed by bul_clr or an exit in cycle N is reusable from cycle N+1, not within the same cycle.
- A shot accepted in the same cycle as move_tick: the new bullet does not step that cycle; other active slots do step.
- bul_clr on an inactive slot has no effect.
- Inactive slots always drive OFF_POS on both axes. Tank positions never equal OFF_POS, so hit checks never match an empty slot.
- bul_en = 0 also zeroes the cooldown counter.
- rst asserted mid-flight returns everything to reset values immediately.

Test Plan:
1. Reset, bul_en=1, tank (5,5) dir 00, bul_sht 0->1 -> next cycle bul1=(5,6), bul_act=0001, shot_ok pulse; after 3 move_ticks bul1=(5,9).
2. Tank (3,19) dir 00, shot request -> spawn cell y=20 is out of grid; no bul_act change, no shot_ok. Tank (0,4) dir 11 -> dropped (underflow).
3. Four accepted shots spaced 2 ticks apart -> slots 1..4 fill in order; fifth request dropped. Pulse bul_clr=0010 -> slot2 = OFF_POS; next accepted shot lands in slot2.
4. Bullet at (14,7) dir 10, move_tick -> (15,7); next move_tick -> slot clears to (31,31) and bul_act bit = 0.
5. COOLDOWN=2: accepted shot, second request before 2 ticks -> dropped; after 2 move_ticks, a request is accepted. bul_sht held high for 10 cycles -> exactly one shot_ok.
6. Shot request and move_tick in the same cycle with slot1 active at (2,2) dir 00 -> slot1 at (2,3), new slot2 at its spawn cell unstepped. Then bul_en=0 -> all bul_act=0000 within 1 clk.

Source files
------------

// File: rtl/mybullet_app.sv
`default_nettype none
// ============================================================================
// Module   : mybullet_app
// Purpose  : Player bullet launcher/tracker, four slots, one cell per move_tick.
// Revision : 1.0  initial release
// ============================================================================
module mybullet_app #(
    parameter int         GRID_X   = 16,
    parameter int         GRID_Y   = 20,
    parameter int         COOLDOWN = 2,
    parameter logic [4:0] OFF_POS  = 5'd31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic       bul_en,
    input  logic       bul_sht,
    input  logic [4:0] tank_x,
    input  logic [4:0] tank_y,
    input  logic [1:0] tank_dir,
    input  logic [3:0] bul_clr,
    output logic [4:0] bul1_x,
    output logic [4:0] bul1_y,
    output logic [4:0] bul2_x,
    output logic [4:0] bul2_y,
    output logic [4:0] bul3_x,
    output logic [4:0] bul3_y,
    output logic [4:0] bul4_x,
    output logic [4:0] bul4_y,
    output logic [3:0] bul_act,
    output logic       shot_ok
);

    localparam int              CD_W       = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] c_COOLDOWN = CD_W'(COOLDOWN);
    localparam logic [5:0]      c_GRID_X   = 6'(GRID_X);
    localparam logic [5:0]      c_GRID_Y   = 6'(GRID_Y);

    logic [4:0]      r_x   [0:3];
    logic [4:0]      r_y   [0:3];
    logic [1:0]      r_dir [0:3];
    logic [3:0]      r_act;
    logic            r_sht_d;
    logic            r_shot_ok;
    logic [CD_W-1:0] r_cd;

    logic [10:0]     w_spawn;
    logic [10:0]     w_nxt [0:3];
    logic [3:0]      w_sel;
    logic            w_found;
    logic            w_req;
    logic            w_accept;

    // Returns {out_of_grid, next_x, next_y}; decrement from 0 counts as leaving the grid.
    function automatic logic [10:0] step(input logic [4:0] x, input logic [4:0] y,
                                         input logic [1:0] d);
        logic [4:0] nx;
        logic [4:0] ny;
        logic       out;
        nx  = x;
        ny  = y;
        out = 1'b0;
        case (d)
            2'b00: ny = y + 5'd1;
            2'b01: begin
                out = (y == 5'd0);
                ny  = y - 5'd1;
            end
            2'b10: nx = x + 5'd1;
            default: begin
                out = (x == 5'd0);
                nx  = x - 5'd1;
            end
        endcase
        if ({1'b0, nx} >= c_GRID_X || {1'b0, ny} >= c_GRID_Y)
            out = 1'b1;
        return {out, nx, ny};
    endfunction

    assign w_spawn  = step(tank_x, tank_y, tank_dir);
    assign w_req    = bul_sht & ~r_sht_d;
    assign w_accept = w_req & bul_en & (r_cd == '0) & ~(&r_act) & ~w_spawn[10];

    always_comb begin
        w_sel   = 4'b0000;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_nxt[i] = step(r_x[i], r_y[i], r_dir[i]);
            if (!r_act[i] && !w_found) begin
                w_sel[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sht_d   <= 1'b0;
            r_shot_ok <= 1'b0;
            r_cd      <= '0;
            r_act     <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_x[i]   <= OFF_POS;
                r_y[i]   <= OFF_POS;
                r_dir[i] <= 2'b00;
            end
        end else begin
            r_sht_d   <= bul_sht;
            r_shot_ok <= w_accept;

            if (!bul_en)
                r_cd <= '0;
            else if (w_accept)
                r_cd <= c_COOLDOWN;
            else if (move_tick && r_cd != '0)
                r_cd <= r_cd - CD_W'(1);

            // Free slots are chosen from the registered flags, so a slot released
            // this cycle only becomes eligible for spawning on the next one.
            for (int i = 0; i < 4; i++) begin
                if (!bul_en) begin
                    r_act[i] <= 1'b0;
                    r_x[i]   <= OFF_POS;
                    r_y[i]   <= OFF_POS;
                end else if (r_act[i]) begin
                    if (bul_clr[i] || (move_tick && w_nxt[i][10])) begin
                        r_act[i] <= 1'b0;
                        r_x[i]   <= OFF_POS;
                        r_y[i]   <= OFF_POS;
                    end else if (move_tick) begin
                        r_x[i] <= w_nxt[i][9:5];
                        r_y[i] <= w_nxt[i][4:0];
                    end
                end else if (w_accept && w_sel[i]) begin
                    r_act[i] <= 1'b1;
                    r_x[i]   <= w_spawn[9:5];
                    r_y[i]   <= w_spawn[4:0];
                    r_dir[i] <= tank_dir;
                end
            end
        end
    end

    assign bul1_x  = r_x[0];
    assign bul1_y  = r_y[0];
    assign bul2_x  = r_x[1];
    assign bul2_y  = r_y[1];
    assign bul3_x  = r_x[2];
    assign bul3_y  = r_y[2];
    assign bul4_x  = r_x[3];
    assign bul4_y  = r_y[3];
    assign bul_act = r_act;
    assign shot_ok = r_shot_ok;

endmodule
`default_nettype wire

// File: tb/tb_mybullet_app.sv
`default_nettype none
// ============================================================================
// Module   : tb_mybullet_app
// Purpose  : Vector table plus directed sequences for mybullet_app.
// Revision : 1.0  initial release
// ============================================================================
module tb_mybullet_app;

    localparam logic [4:0] O = 5'd31;

    logic       clk = 1'b0;
    logic       rst;
    logic       move_tick, bul_en, bul_sht;
    logic [4:0] tank_x, tank_y;
    logic [1:0] tank_dir;
    logic [3:0] bul_clr;
    logic [4:0] bul1_x, bul1_y, bul2_x, bul2_y, bul3_x, bul3_y, bul4_x, bul4_y;
    logic [3:0] bul_act;
    logic       shot_ok;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       en, sht, tick;
        logic [4:0] tx, ty;
        logic [1:0] dir;
        logic [3:0] clr;
        logic [3:0] act;
        logic       ok;
        logic [4:0] x1, y1, x2, y2;
    } vec_t;

    vec_t vecs [0:22];

    mybullet_app #(.GRID_X(16), .GRID_Y(20), .COOLDOWN(2), .OFF_POS(5'd31)) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .bul_en(bul_en), .bul_sht(bul_sht),
        .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .bul_clr(bul_clr),
        .bul1_x(bul1_x), .bul1_y(bul1_y), .bul2_x(bul2_x), .bul2_y(bul2_y),
        .bul3_x(bul3_x), .bul3_y(bul3_y), .bul4_x(bul4_x), .bul4_y(bul4_y),
        .bul_act(bul_act), .shot_ok(shot_ok)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic sht, input logic tick,
                                input logic [4:0] tx, input logic [4:0] ty,
                                input logic [1:0] dir, input logic [3:0] clr,
                                input logic [3:0] act, input logic ok,
                                input logic [4:0] x1, input logic [4:0] y1,
                                input logic [4:0] x2, input logic [4:0] y2);
        vec_t v;
        v.en = en; v.sht = sht; v.tick = tick; v.tx = tx; v.ty = ty; v.dir = dir;
        v.clr = clr; v.act = act; v.ok = ok; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [39:0] act_v, input logic [39:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    endtask

    task automatic cyc(input logic en, input logic sht, input logic tick,
                       input logic [4:0] tx, input logic [4:0] ty,
                       input logic [1:0] dir, input logic [3:0] clr);
        bul_en = en; bul_sht = sht; move_tick = tick;
        tank_x = tx; tank_y = ty; tank_dir = dir; bul_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bul_en = 1'b1; bul_sht = 1'b0; move_tick = 1'b0;
        tank_x = 5'd5; tank_y = 5'd5; tank_dir = 2'b00; bul_clr = 4'b0000;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] all_pos();
        return {bul1_x, bul1_y, bul2_x, bul2_y, bul3_x, bul3_y, bul4_x, bul4_y};
    endfunction

    int ok_cnt;

    initial begin
        vecs[0]  = mk(1,1,0, 5, 5,0,4'h0, 4'h1,1, 5, 6, O, O);
        vecs[1]  = mk(1,1,1, 5, 5,0,4'h0, 4'h1,0, 5, 7, O, O);
        vecs[2]  = mk(1,0,1, 5, 5,0,4'h0, 4'h1,0, 5, 8, O, O);
        vecs[3]  = mk(1,0,1, 5, 5,0,4'h0, 4'h1,0, 5, 9, O, O);
        vecs[4]  = mk(1,1,0, 3,19,0,4'h0, 4'h1,0, 5, 9, O, O);
        vecs[5]  = mk(1,0,0, 3,19,0,4'h0, 4'h1,0, 5, 9, O, O);
        vecs[6]  = mk(1,1,0, 0, 4,3,4'h0, 4'h1,0, 5, 9, O, O);
        vecs[7]  = mk(1,0,0, 0, 4,3,4'h0, 4'h1,0, 5, 9, O, O);
        vecs[8]  = mk(1,1,0,13, 7,2,4'h0, 4'h3,1, 5, 9,14, 7);
        vecs[9]  = mk(1,0,1,13, 7,2,4'h0, 4'h3,0, 5,10,15, 7);
        vecs[10] = mk(1,0,1,13, 7,2,4'h0, 4'h1,0, 5,11, O, O);
        vecs[11] = mk(1,0,0,13, 7,2,4'h1, 4'h0,0, O, O, O, O);
        vecs[12] = mk(1,0,1,13, 7,2,4'h2, 4'h0,0, O, O, O, O);
        vecs[13] = mk(1,1,0, 5, 5,0,4'h0, 4'h1,1, 5, 6, O, O);
        vecs[14] = mk(1,0,0, 5, 5,0,4'h0, 4'h1,0, 5, 6, O, O);
        vecs[15] = mk(1,1,0, 5, 5,1,4'h0, 4'h1,0, 5, 6, O, O);
        vecs[16] = mk(1,0,1, 5, 5,1,4'h0, 4'h1,0, 5, 7, O, O);
        vecs[17] = mk(1,1,0, 5, 5,1,4'h0, 4'h1,0, 5, 7, O, O);
        vecs[18] = mk(1,0,1, 5, 5,1,4'h0, 4'h1,0, 5, 8, O, O);
        vecs[19] = mk(1,1,0, 5, 5,1,4'h0, 4'h3,1, 5, 8, 5, 4);
        vecs[20] = mk(0,0,0, 5, 5,1,4'h0, 4'h0,0, O, O, O, O);
        vecs[21] = mk(1,1,0, 5, 5,0,4'h0, 4'h1,1, 5, 6, O, O);
        vecs[22] = mk(1,0,0, 5, 5,0,4'h0, 4'h1,0, 5, 6, O, O);

        do_reset();
        chk("reset_act", 40'(bul_act), 40'h0);
        chk("reset_ok",  40'(shot_ok), 40'h0);
        chk("reset_pos", all_pos(), {8{O}});

        for (int i = 0; i < 23; i++) begin
            cyc(vecs[i].en, vecs[i].sht, vecs[i].tick, vecs[i].tx, vecs[i].ty,
                vecs[i].dir, vecs[i].clr);
            chk($sformatf("v%0d_act", i), 40'(bul_act), 40'(vecs[i].act));
            chk($sformatf("v%0d_ok", i),  40'(shot_ok), 40'(vecs[i].ok));
            chk($sformatf("v%0d_pos", i), all_pos(),
                {vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, O, O, O, O});
        end

        // Level held high must fire exactly once.
        do_reset();
        ok_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1,1,0, 5,5,0,4'h0);
            if (shot_ok) ok_cnt++;
        end
        chk("held_sht_once", 40'(ok_cnt), 40'd1);

        // Fill all four slots, overflow request, clear slot2, refill slot2.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1,1,0, 0,3,2,4'h0);
            chk($sformatf("fill%0d_ok", k), 40'(shot_ok), 40'd1);
            cyc(1,0,1, 0,3,2,4'h0);
            cyc(1,0,1, 0,3,2,4'h0);
        end
        chk("fill_act", 40'(bul_act), 40'hF);
        chk("fill_slot1", 40'({bul1_x, bul1_y}), 40'({5'd9, 5'd3}));
        cyc(1,1,0, 0,3,2,4'h0);
        chk("fifth_ok", 40'(shot_ok), 40'd0);
        chk("fifth_act", 40'(bul_act), 40'hF);
        cyc(1,0,0, 0,3,2,4'h0);
        cyc(1,0,0, 0,3,2,4'h2);
        chk("clr2_act", 40'(bul_act), 40'hD);
        chk("clr2_pos", 40'({bul2_x, bul2_y}), 40'({O, O}));
        cyc(1,1,0, 3,3,0,4'h0);
        chk("refill_ok", 40'(shot_ok), 40'd1);
        chk("refill_act", 40'(bul_act), 40'hF);
        chk("refill_pos", 40'({bul2_x, bul2_y}), 40'({5'd3, 5'd4}));

        // Shot accepted in a move_tick cycle: old bullet steps, new one does not.
        do_reset();
        cyc(1,1,0, 2,1,0,4'h0);
        cyc(1,0,1, 2,1,0,4'h0);
        cyc(1,0,1, 2,1,0,4'h0);
        chk("pre_tick_pos", 40'({bul1_x, bul1_y}), 40'({5'd2, 5'd4}));
        cyc(1,1,1, 7,7,3,4'h0);
        chk("tick_shot_ok", 40'(shot_ok), 40'd1);
        chk("tick_shot_pos", all_pos(), {5'd2, 5'd5, 5'd6, 5'd7, O, O, O, O});
        cyc(0,0,0, 7,7,3,4'h0);
        chk("disable_act", 40'(bul_act), 40'h0);
        chk("disable_pos", all_pos(), {8{O}});

        // Asynchronous reset takes effect between clock edges.
        cyc(1,1,0, 5,5,0,4'h0);
        cyc(1,0,0, 5,5,0,4'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_act", 40'(bul_act), 40'h0);
        chk("async_rst_pos", 40'({bul1_x, bul1_y}), 40'({O, O}));
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
